// File: rtl/systolic_pkg.sv
// Shared constants and state type for the systolic west-edge row feeder.
package systolic_pkg;
   localparam int ROWS       = 4;
   localparam int DATA_WIDTH = 16;
   localparam int K_LEN      = 9;
   localparam int T_W        = 4;
   localparam int T_LAST     = K_LEN + ROWS - 2;
   localparam int DRAIN_CYC  = 2;
   localparam int DC_W       = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } feeder_state_t;
endpackage

// File: rtl/systolic_row_feeder_if.sv
// Control, FIFO-read and array-side bundle of the row feeder.
interface systolic_row_feeder_if;
   import systolic_pkg::*;

   logic                       start;
   logic                       busy;
   logic                       done;
   logic [ROWS-1:0]            fifo_empty;
   logic [ROWS-1:0]            fifo_ren;
   logic [ROWS*DATA_WIDTH-1:0] fifo_dout;
   logic [ROWS*DATA_WIDTH-1:0] a_out;
   logic [ROWS-1:0]            a_valid;
   logic                       a_en;

   modport master (
      output start, fifo_empty, fifo_dout,
      input  busy, done, fifo_ren, a_out, a_valid, a_en
   );

   modport slave (
      input  start, fifo_empty, fifo_dout,
      output busy, done, fifo_ren, a_out, a_valid, a_en
   );
endinterface

// File: rtl/systolic_row_feeder_row_read_window.sv
// Per-row read window: row ROW is scheduled while ROW <= t <= ROW+K_LEN-1.
module row_read_window
   import systolic_pkg::*;
#(
   parameter int ROW = 0
) (
   input  logic [T_W-1:0] i_t,
   output logic           o_sched
);
   localparam logic [T_W:0] LO = (T_W+1)'(ROW);
   localparam logic [T_W:0] HI = (T_W+1)'(ROW + K_LEN - 1);

   logic [T_W:0] w_t;
   assign w_t = {1'b0, i_t};

   generate
      if (ROW == 0) begin : g_first
         assign o_sched = (w_t <= HI);
      end else begin : g_rest
         assign o_sched = (w_t >= LO) && (w_t <= HI);
      end
   endgenerate
endmodule

// File: rtl/systolic_row_feeder.sv
// Skewed read controller draining the per-row operand FIFOs into the array.
module systolic_row_feeder
   import systolic_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   systolic_row_feeder_if.slave  bus
);
   localparam logic [T_W-1:0]  T_END = T_W'(T_LAST);
   localparam logic [DC_W-1:0] D_END = DC_W'(DRAIN_CYC - 1);

   feeder_state_t              r_state, w_state_nx;
   logic [T_W-1:0]             r_t, w_t_nx;
   logic [DC_W-1:0]            r_dcnt, w_dcnt_nx;
   logic [ROWS-1:0]            w_sched;
   logic [ROWS-1:0]            w_ren;
   logic                       w_ok;
   logic                       w_step;
   logic [ROWS-1:0]            r_ren_d;
   logic                       r_step_d;
   logic [ROWS*DATA_WIDTH-1:0] r_a_out;
   logic [ROWS-1:0]            r_a_valid;
   logic                       r_a_en;

   generate
      for (genvar g = 0; g < ROWS; g++) begin : g_win
         row_read_window #(.ROW(g)) u_win (
            .i_t     (r_t),
            .o_sched (w_sched[g])
         );
      end
   endgenerate

   // Any scheduled row running dry freezes every row so the skew survives.
   always_comb begin
      w_ok   = ~|(w_sched & bus.fifo_empty);
      w_step = (r_state == RUN) && w_ok;
      w_ren  = w_step ? w_sched : '0;
   end

   always_comb begin
      w_state_nx = r_state;
      w_t_nx     = r_t;
      w_dcnt_nx  = r_dcnt;
      unique case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nx = RUN;
               w_t_nx     = '0;
            end
         end
         RUN: begin
            if (w_ok) begin
               w_t_nx = r_t + 1'b1;
               if (r_t == T_END) begin
                  w_state_nx = DRAIN;
                  w_dcnt_nx  = '0;
               end
            end
         end
         DRAIN: begin
            w_dcnt_nx = r_dcnt + 1'b1;
            if (r_dcnt == D_END) w_state_nx = DONE;
         end
         DONE: w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_t       <= '0;
         r_dcnt    <= '0;
         r_ren_d   <= '0;
         r_step_d  <= 1'b0;
         r_a_out   <= '0;
         r_a_valid <= '0;
         r_a_en    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_t       <= w_t_nx;
         r_dcnt    <= w_dcnt_nx;
         r_ren_d   <= w_ren;
         r_step_d  <= w_step;
         r_a_out   <= bus.fifo_dout;
         r_a_valid <= r_ren_d;
         r_a_en    <= r_step_d;
      end
   end

   assign bus.busy     = (r_state != IDLE);
   assign bus.done     = (r_state == DONE);
   assign bus.fifo_ren = w_ren;
   assign bus.a_out    = r_a_out;
   assign bus.a_valid  = r_a_valid;
   assign bus.a_en     = r_a_en;
endmodule

// File: doc/systolic_row_feeder.md
Name: systolic_row_feeder

Overview:
Downstream read controller for the ROWS per-row operand FIFOs that feed the systolic array's west edge. On start it drains K_LEN words from every row FIFO with a one-cycle diagonal skew per row (row r begins r cycles after row 0). It registers the FIFO outputs and presents them to the array with per-row valid bits and a global array enable. A stall on any empty FIFO freezes the whole schedule, so the skew is preserved.

Parameters:
ROWS, 4, number of array rows and row FIFOs
DATA_WIDTH, 16, operand width; matches FIFO data width
K_LEN, 9, words read per row per tile; equals FIFO depth
T_W, 4, schedule counter width; must satisfy 2^T_W > K_LEN+ROWS-2

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle request to stream one tile
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the last operand has been presented
fifo_empty  in  ROWS  per-row FIFO empty flags
fifo_ren  out  ROWS  per-row FIFO read enables; combinational from state, counter and fifo_empty
fifo_dout  in  ROWS*DATA_WIDTH  per-row FIFO read data; row r at [r*DATA_WIDTH +: DATA_WIDTH]; valid 1 cycle after ren, zero otherwise
a_out  out  ROWS*DATA_WIDTH  registered operands to array, same packing
a_valid  out  ROWS  registered per-row valid
a_en  out  1  registered array step enable

Behaviour:
- Reset: state IDLE, t=0, busy=0, done=0, a_out=0, a_valid=0, a_en=0, fifo_ren=0. Reset mid-tile aborts the tile; external FIFO contents are not touched.
- FSM states:
  - IDLE: start -> RUN and t=0.
  - RUN: schedule active.
  - DRAIN: two cycles, flushing the FIFO read latency plus the output register.
  - DONE: asserts done for one cycle, then goes to IDLE.
- busy=1 in RUN, DRAIN and DONE. start is ignored unless the state is IDLE.
- Read window: row r is scheduled in RUN when r <= t <= r+K_LEN-1.
- Stall: sched_ok = no scheduled row has fifo_empty=1.
  - If sched_ok: fifo_ren[r] = scheduled(r) and t increments.
  - Otherwise: fifo_ren = 0 for all rows and t holds.
  - Unscheduled rows never read, even if their FIFO is non-empty.
- RUN -> DRAIN on the cycle t = K_LEN+ROWS-2 with sched_ok=1 (the last read issues that cycle).
- Pipeline: step_c = (RUN and sched_ok); ren_d = fifo_ren delayed 1 cycle.
  - Cycle c+1: fifo_dout is valid.
  - Cycle c+2: a_out[r] = fifo_dout[r] registered, a_valid[r] = ren_d[r], a_en = step_c delayed 2 cycles.
  - Total latency is 2 cycles from fifo_ren to a_out/a_valid.
- Skew padding: when a_en=1, rows outside their window show a_valid=0 and a_out=0. The FIFO drives zero dout when not read, so zero padding follows naturally.
- Stall cycles propagate as a_en=0 with a_out=0 two cycles later. The array holds state when a_en=0.
- done pulses in the cycle after the final a_en=1. Total cycles from start to done with no stalls: K_LEN+ROWS-1 (RUN) + 2 (DRAIN) + 1 = 15 for the defaults.
- Empty during an unscheduled window (for example, row 3 empty at t=0..2) does not stall.
- start while in DONE is ignored; the caller re-issues it after busy falls.

Decomposition:
- Shared package systolic_pkg:
  - feeder_state_t enum (IDLE, RUN, DRAIN, DONE)
  - localparam T_LAST = K_LEN+ROWS-2
  - localparam DRAIN_CYC = 2
- One natural sub-module: row_read_window.
  - Combinational per-row compare r <= t <= r+K_LEN-1.
  - Instantiated ROWS times via generate; outputs the scheduled vector.
- Everything else (FSM, counter, output registers) stays in systolic_row_feeder.

Test Plan:
- Nominal tile: all FIFOs pre-filled, row r word k = 16'h(r)(k), start at cycle 0.
  - fifo_ren[0] high cycles 0-8; fifo_ren[3] high cycles 3-11.
  - a_out row 0 = 0x0000..0x0008 on cycles 2-10; row 3 = 0x0300..0x0308 on cycles 5-13.
  - a_en high cycles 2-13; done pulses at cycle 14; busy falls at cycle 15.
- Stall: row 1 FIFO empty while t=4, released after 3 cycles.
  - No fifo_ren in any row for 3 cycles; t holds at 4.
  - a_en low for 3 cycles mid-stream; relative skew unchanged; done delayed by exactly 3 cycles (cycle 17).
- Unscheduled empty: row 3 empty until t=3.
  - No stall; timing identical to the nominal tile.
- Start while busy: second start pulse at cycle 5.
  - Ignored; exactly 36 reads (9 per row) total; single done pulse.
- Reset mid-tile: rstn low at cycle 6 for 2 cycles.
  - All outputs 0 asynchronously; state IDLE.
  - A new start after release runs a fresh schedule from t=0.
- Back-to-back tiles: start asserted in the cycle busy falls.
  - Accepted; second tile's fifo_ren[0] rises the next cycle; 72 words are delivered in order.
